// File: rtl/multi_edge_detector.sv
// ============================================================================
// multi_edge_detector: N-channel glitch-filtered Moore edge detector with
// per-channel mode, sticky pending flags and a combined any-edge output.
// Optional input synchronizer: define MULTI_EDGE_SYNC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_edge_detector #(
  parameter int N      = 4,
  parameter int FILTER = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   level,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   edg,
  output logic [N-1:0]   pending,
  output logic           any_edg
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(FILTER - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    R_EDG = 2'd1,
    ONE   = 2'd2,
    F_EDG = 2'd3
  } state_t;

  logic [N-1:0] w_x;

`ifdef MULTI_EDGE_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= level;
      r_sync2 <= r_sync1;
    end
  end

  assign w_x = r_sync2;
`else
  assign w_x = level;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          r_s;
    logic [CW-1:0] r_cnt;
    logic          w_accept;
    logic          w_f;
    state_t        r_state;
    state_t        w_next;

    // f is the filtered level, already showing an accepted change this cycle
    always_comb begin
      w_accept = (w_x[i] != r_s) && (r_cnt == c_cnt_last);
      w_f      = w_accept ? w_x[i] : r_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s   <= 1'b0;
        r_cnt <= '0;
      end else if (w_x[i] == r_s) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_s   <= w_x[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    always_comb begin
      w_next = ZERO;
      case (r_state)
        ZERO:    w_next = w_f ? R_EDG : ZERO;
        R_EDG:   w_next = w_f ? ONE   : F_EDG;
        ONE:     w_next = w_f ? ONE   : F_EDG;
        F_EDG:   w_next = w_f ? R_EDG : ZERO;
        default: w_next = ZERO;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ZERO;
      else        r_state <= w_next;
    end

    // mode only gates the decode, so the FSM never misses a transition
    assign edg[i] = ((r_state == R_EDG) & mode[2*i]) |
                    ((r_state == F_EDG) & mode[2*i+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending[i] <= 1'b0;
      else        pending[i] <= edg[i] | (pending[i] & ~clr[i]);
    end
  end : g_ch

  assign any_edg = |edg;

endmodule

`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench: two DUTs (FILTER=1 and FILTER=4) share stimulus; a
// run-length reference model predicts edg/pending/any_edg for each.
`default_nettype none

module tb_multi_edge_detector;
  localparam int N      = 4;
  localparam int FILT_A = 1;
  localparam int FILT_B = 4;
`ifdef MULTI_EDGE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   level;
  logic [2*N-1:0] mode;
  logic [N-1:0]   clr;
  logic [N-1:0]   edg_a, pend_a, edg_b, pend_b;
  logic           any_a, any_b;

  always #5 clk = ~clk;

  multi_edge_detector #(.N(N), .FILTER(FILT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .level(level), .mode(mode), .clr(clr),
    .edg(edg_a), .pending(pend_a), .any_edg(any_a));

  multi_edge_detector #(.N(N), .FILTER(FILT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .level(level), .mode(mode), .clr(clr),
    .edg(edg_b), .pending(pend_b), .any_edg(any_b));

  typedef struct packed {
    logic [N-1:0] e0;
    logic [N-1:0] p0;
    logic         a0;
    logic [N-1:0] e1;
    logic [N-1:0] p1;
    logic         a1;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model state
  logic [N-1:0] acc [2];
  logic [N-1:0] rise [2];
  logic [N-1:0] fall [2];
  logic [N-1:0] pend [2];
  logic [N-1:0] expedg [2];
  logic [N-1:0] sd1, sd2, lastx;
  int           run [N];

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      acc[d] = '0; rise[d] = '0; fall[d] = '0; pend[d] = '0; expedg[d] = '0;
    end
    sd1 = '0; sd2 = '0; lastx = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
  endtask

  // advance the model by one rising edge using the inputs present at the edge
  task automatic model_edge();
    logic [N-1:0] x;
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 2; d++) pend[d] = expedg[d] | (pend[d] & ~clr);
    x   = SYNC ? sd2 : level;
    sd2 = sd1;
    sd1 = level;
    for (int i = 0; i < N; i++) begin
      if (run[i] > 0 && x[i] == lastx[i]) run[i] = (run[i] < 100) ? run[i] + 1 : 100;
      else run[i] = 1;
      lastx[i] = x[i];
      for (int d = 0; d < 2; d++) begin
        if (run[i] >= ((d == 0) ? FILT_A : FILT_B) && x[i] != acc[d][i]) begin
          acc[d][i]  = x[i];
          rise[d][i] = x[i];
          fall[d][i] = ~x[i];
        end else begin
          rise[d][i] = 1'b0;
          fall[d][i] = 1'b0;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++)
        expedg[d][i] = (rise[d][i] & mode[2*i]) | (fall[d][i] & mode[2*i+1]);
    e.e0 = expedg[0]; e.p0 = pend[0]; e.a0 = |expedg[0];
    e.e1 = expedg[1]; e.p1 = pend[1]; e.a1 = |expedg[1];
    q.push_back(e);
  endtask

  task automatic cyc(input logic [N-1:0] lv, input logic [2*N-1:0] md,
                     input logic [N-1:0] cl, input logic rn);
    @(posedge clk);
    model_edge();
    #1;
    level = lv; mode = md; clr = cl; rst_n = rn;
    if (!rst_n) model_clear();
    push_expected();
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp_v);
    end
  endtask

  // monitor: every cycle presents an output; compare against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("edg_f1",     edg_a,  e.e0);
        chk("pending_f1", pend_a, e.p0);
        chk("any_edg_f1", {{(N-1){1'b0}}, any_a}, {{(N-1){1'b0}}, e.a0});
        chk("edg_f4",     edg_b,  e.e1);
        chk("pending_f4", pend_b, e.p1);
        chk("any_edg_f4", {{(N-1){1'b0}}, any_b}, {{(N-1){1'b0}}, e.a1});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0]   lv;
    logic [2*N-1:0] md;
    logic [N-1:0]   cl;
    int             hold [N];
    level = '0; mode = '1; clr = '0; rst_n = 1'b0;
    model_clear();
    repeat (3) cyc('0, '1, '0, 1'b0);
    repeat (9) cyc('0, '1, '0, 1'b1);
    // channel 0 rise then fall, all modes both
    repeat (10) cyc(4'b0001, '1, '0, 1'b1);
    repeat (10) cyc(4'b0000, '1, '0, 1'b1);
    // channel 1 rise-only, then switch to fall-only while high
    for (int k = 0; k < 3; k++) begin
      repeat (6) cyc(4'b0010, 8'hF7, '0, 1'b1);
      repeat (6) cyc(4'b0000, 8'hF7, '0, 1'b1);
    end
    repeat (6) cyc(4'b0010, 8'hF7, '0, 1'b1);
    repeat (2) cyc(4'b0010, 8'hFB, '0, 1'b1);
    repeat (8) cyc(4'b0000, 8'hFB, '0, 1'b1);
    // channel 2 short and just-long-enough pulses
    repeat (3) cyc(4'b0100, '1, '0, 1'b1);
    repeat (8) cyc(4'b0000, '1, '0, 1'b1);
    repeat (4) cyc(4'b0100, '1, '0, 1'b1);
    repeat (8) cyc(4'b0000, '1, '0, 1'b1);
    // single-cycle glitch on channel 1
    cyc(4'b0010, '1, '0, 1'b1);
    repeat (6) cyc(4'b0000, '1, '0, 1'b1);
    // channel 3 pending with clear overlapping the fall pulse
    repeat (8) cyc(4'b1000, '1, '0, 1'b1);
    repeat (8) cyc(4'b0000, '1, 4'b1000, 1'b1);
    repeat (3) cyc(4'b0000, '1, '0, 1'b1);
    // reset asserted mid-pulse with level held high
    repeat (2) cyc(4'b1111, '1, '0, 1'b1);
    repeat (3) cyc(4'b1111, '1, '0, 1'b0);
    repeat (10) cyc(4'b1111, '1, '0, 1'b1);
    repeat (8) cyc(4'b0000, '1, '0, 1'b1);
    // randomized phase
    lv = '0; md = '1;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          lv[i]   = ~lv[i];
          hold[i] = $urandom_range(1, 7);
        end
        hold[i]--;
        cl[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 15) == 0) md = 8'($urandom);
      cyc(lv, md, cl, ($urandom_range(0, 199) != 0));
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
